// File: rtl/eth_descriptor_memory_dp_pkg.sv
// rtl/eth_descriptor_memory_dp_pkg.sv - shared state codes and lane-merge helper for the descriptor RAM
package eth_desc_mem_pkg;

  typedef logic [0:0] state_t;
  localparam state_t CLEAR = 1'b0;
  localparam state_t READY = 1'b1;

  // Helper is sized for the widest supported word; callers cast in and out.
  localparam int MAX_DATA_WIDTH = 1024;
  localparam int MAX_LANES      = MAX_DATA_WIDTH / 8;

  function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_LANES-1:0]      byteenable
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    for (int i = 0; i < MAX_LANES; i++) begin
      merged[i*8 +: 8] = byteenable[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/eth_descriptor_memory_dp_if.sv
// rtl/eth_descriptor_memory_dp_if.sv - Avalon-MM slave port bundle for one side of the descriptor RAM
interface eth_descriptor_memory_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) ();

  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid, waitrequest
  );

endinterface

// File: rtl/eth_desc_mem_port_ctrl.sv
// rtl/eth_desc_mem_port_ctrl.sv - per-port accept, cross-port forwarding and readdatavalid pipeline
// DESC_MEM_OUTREG_EN adds a second output register stage (read latency 2).
module eth_desc_mem_port_ctrl
  import eth_desc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    busy,
  eth_descriptor_memory_dp_if.slave bus,
  input  logic [DATA_WIDTH-1:0]   mem_word,
  input  logic                    other_write,
  input  logic [ADDR_WIDTH-1:0]   other_address,
  input  logic [DATA_WIDTH/8-1:0] other_byteenable,
  input  logic [DATA_WIDTH-1:0]   other_writedata,
  output logic                    write_en
);

  localparam int LANES = DATA_WIDTH / 8;

  logic                  read_en;
  logic [LANES-1:0]      fwd_be;
  logic [DATA_WIDTH-1:0] read_word;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign bus.waitrequest = busy;
  assign write_en = bus.chipselect & bus.write & ~busy & clken;
  assign read_en  = bus.chipselect & bus.read & ~bus.write & ~busy & clken;

  // The array still holds the old word this cycle; overlay the other port's write lanes.
  assign fwd_be    = (other_write && (other_address == bus.address)) ? other_byteenable : '0;
  assign read_word = DATA_WIDTH'(lane_merge(MAX_DATA_WIDTH'(mem_word),
                                            MAX_DATA_WIDTH'(other_writedata),
                                            MAX_LANES'(fwd_be)));

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clken) begin
      valid_q <= read_en;
      if (read_en) data_q <= read_word;
    end
  end

`ifdef DESC_MEM_OUTREG_EN
  logic                  valid_o;
  logic [DATA_WIDTH-1:0] data_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (clken) begin
      valid_o <= valid_q;
      if (valid_q) data_o <= data_q;
    end
  end

  assign bus.readdatavalid = valid_o & clken;
  assign bus.readdata      = data_o;
`else
  // A frozen pipeline must not present its pending pulse while clken is low.
  assign bus.readdatavalid = valid_q & clken;
  assign bus.readdata      = data_q;
`endif

endmodule

// File: rtl/eth_descriptor_memory_dp.sv
// rtl/eth_descriptor_memory_dp.sv - dual-port descriptor RAM with post-reset clear and collision arbitration
// DESC_MEM_OUTREG_EN (in eth_desc_mem_port_ctrl) selects read latency 2 instead of 1.
module eth_descriptor_memory_dp
  import eth_desc_mem_pkg::*;
#(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 11,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = "eth_descriptor_memory_dp.hex"
) (
  input  logic clk,
  input  logic reset,
  input  logic clken,
  eth_descriptor_memory_dp_if.slave s1,
  eth_descriptor_memory_dp_if.slave s2,
  output logic clear_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / 8;

  if ((DATA_WIDTH % 8 != 0) || (DATA_WIDTH > MAX_DATA_WIDTH)) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8 and at most MAX_DATA_WIDTH");
  end
  if ((CLEAR_ON_RESET == 0) && (INIT_FILE == "")) begin : g_no_init
    $error("CLEAR_ON_RESET=0 requires INIT_FILE for defined contents");
  end

  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [ADDR_WIDTH-1:0] clear_count;
  logic                  busy;
  logic                  wr1;
  logic                  wr2;
  logic [DATA_WIDTH-1:0] word1;
  logic [DATA_WIDTH-1:0] word2;

  assign busy       = (state == CLEAR);
  assign clear_busy = busy;
  assign word1      = mem[s1.address];
  assign word2      = mem[s2.address];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clear_count <= '0;
    end else if (clken && busy) begin
      clear_count <= clear_count + ADDR_WIDTH'(1);
      if (&clear_count) state <= READY;
    end
  end

  // s1 lanes are assigned last so they win overlapping lanes of a same-address collision.
  always_ff @(posedge clk) begin
    if (busy && clken && !reset) mem[clear_count] <= '0;
    for (int i = 0; i < LANES; i++) begin
      if (wr2 && s2.byteenable[i]) mem[s2.address][i*8 +: 8] <= s2.writedata[i*8 +: 8];
      if (wr1 && s1.byteenable[i]) mem[s1.address][i*8 +: 8] <= s1.writedata[i*8 +: 8];
    end
  end

  eth_desc_mem_port_ctrl #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_port1 (
    .clk(clk), .reset(reset), .clken(clken), .busy(busy), .bus(s1),
    .mem_word(word1), .other_write(wr2), .other_address(s2.address),
    .other_byteenable(s2.byteenable), .other_writedata(s2.writedata), .write_en(wr1)
  );

  eth_desc_mem_port_ctrl #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_port2 (
    .clk(clk), .reset(reset), .clken(clken), .busy(busy), .bus(s2),
    .mem_word(word2), .other_write(wr1), .other_address(s1.address),
    .other_byteenable(s1.byteenable), .other_writedata(s1.writedata), .write_en(wr2)
  );

endmodule

// File: tb/tb_eth_descriptor_memory_dp.sv
// tb/tb_eth_descriptor_memory_dp.sv - scoreboard bench for the dual-port descriptor RAM
`timescale 1ns/1ps
module tb_eth_descriptor_memory_dp;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef DESC_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  logic clken;
  logic clear_busy;

  always #5 clk = ~clk;

  eth_descriptor_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s1_if ();
  eth_descriptor_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) s2_if ();

  eth_descriptor_memory_dp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1), .INIT_FILE("eth_descriptor_memory_dp.hex")
  ) dut (
    .clk(clk), .reset(reset), .clken(clken), .s1(s1_if), .s2(s2_if), .clear_busy(clear_busy)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  int            checks = 0;
  int            passed = 0;
  int            en_edges = 0;
  bit            model_ready = 0;
  logic [DW-1:0] ref_mem [DEPTH];
  exp_t          q1[$];
  exp_t          q2[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
  endtask

  function automatic logic [DW-1:0] merge_ref(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                              input logic [3:0] be);
    logic [DW-1:0] mask = '0;
    for (int i = 0; i < 4; i++) if (be[i]) mask |= 32'hFF << (8 * i);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // Spec-level model: all writes of a cycle land together (s1 lanes win a same-address
  // collision) and any read accepted in that cycle observes the post-write memory.
  task automatic model_step(input int op1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic [3:0] b1,
                            input int op2, input logic [AW-1:0] a2, input logic [DW-1:0] d2, input logic [3:0] b2);
    logic [DW-1:0] w1;
    logic [DW-1:0] w2;
    w1 = (op1 >= 2) ? d1 : '0;
    w2 = (op2 >= 2) ? d2 : '0;
    if (op1 >= 2 && op2 >= 2 && a1 == a2) begin
      ref_mem[a1] = merge_ref(merge_ref(ref_mem[a1], w2, b2 & ~b1), w1, b1);
    end else begin
      if (op1 >= 2) ref_mem[a1] = merge_ref(ref_mem[a1], w1, b1);
      if (op2 >= 2) ref_mem[a2] = merge_ref(ref_mem[a2], w2, b2);
    end
    if (op1 == 1) q1.push_back('{ref_mem[a1], en_edges + LAT - 1});
    if (op2 == 1) q2.push_back('{ref_mem[a2], en_edges + LAT - 1});
  endtask

  // op: 0 idle, 1 read, 2 write, 3 read+write
  task automatic drive(input int p, input int op, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] b);
    if (p == 1) begin
      s1_if.chipselect = (op != 0); s1_if.read = (op == 1 || op == 3); s1_if.write = (op >= 2);
      s1_if.address = a; s1_if.writedata = d; s1_if.byteenable = b;
    end else begin
      s2_if.chipselect = (op != 0); s2_if.read = (op == 1 || op == 3); s2_if.write = (op >= 2);
      s2_if.address = a; s2_if.writedata = d; s2_if.byteenable = b;
    end
  endtask

  task automatic idle();
    drive(1, 0, '0, '0, '0);
    drive(2, 0, '0, '0, '0);
  endtask

  task automatic do_cycle(input int op1, input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic [3:0] b1,
                          input int op2, input logic [AW-1:0] a2, input logic [DW-1:0] d2, input logic [3:0] b2,
                          input bit en);
    drive(1, op1, a1, d1, b1);
    drive(2, op2, a2, d2, b2);
    clken = en;
    @(posedge clk);
    if (en) begin
      en_edges++;
      if (model_ready) model_step(op1, a1, d1, b1, op2, a2, d2, b2);
    end
    #1;
    idle();
    clken = 1'b1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, '0, '0, '0, 0, '0, '0, '0, 1'b1);
  endtask

  task automatic apply_reset(input int cycles);
    model_ready = 0;
    idle();
    clken = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      en_edges++;
    end
    #1;
    reset = 1'b0;
    q1.delete();
    q2.delete();
  endtask

  // Counts busy cycles while offering requests that must be ignored.
  task automatic measure_clear(input string name, input int want);
    int n = 0;
    bit done = 0;
    drive(1, 2, 4'd2, 32'hFFFF_FFFF, 4'hF);
    drive(2, 1, 4'd3, '0, '0);
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (clear_busy === 1'b1 && s1_if.waitrequest === 1'b1 && s2_if.waitrequest === 1'b1) n++;
      else begin
        done = 1;
        idle();
      end
      @(posedge clk);
      en_edges++;
      #1;
    end
    check(name, 64'(n), 64'(want));
    check({name, "_wait_low"}, 64'({s1_if.waitrequest, s2_if.waitrequest, clear_busy}), 64'(0));
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_ready = 1;
  endtask

  task automatic pop_check(input int p, input logic [DW-1:0] d);
    exp_t e;
    checks++;
    if ((p == 1 && q1.size() == 0) || (p == 2 && q2.size() == 0)) begin
      $display("FAIL s%0d_unexpected_valid: got readdatavalid=1 data 0x%0h, required no pending read", p, d);
      return;
    end
    if (p == 1) e = q1.pop_front();
    else        e = q2.pop_front();
    if (d === e.data && en_edges == e.due) passed++;
    else $display("FAIL s%0d_read: got data 0x%0h at enabled edge %0d, required 0x%0h at %0d",
                  p, d, en_edges, e.data, e.due);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (s1_if.readdatavalid === 1'b1) pop_check(1, s1_if.readdata);
      if (s2_if.readdatavalid === 1'b1) pop_check(2, s2_if.readdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within 200us");
    $fatal(1);
  end

  initial begin
    int op1, op2;
    logic [AW-1:0] a1, a2;
    bit en;

    reset = 1'b1;
    clken = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 64'({s1_if.readdatavalid, s2_if.readdatavalid}), 64'(0));
    check("rst_s1_readdata", 64'(s1_if.readdata), 64'(0));
    check("rst_s2_readdata", 64'(s2_if.readdata), 64'(0));
    check("rst_busy_wait", 64'({clear_busy, s1_if.waitrequest, s2_if.waitrequest}), 64'(3'b111));
    @(posedge clk);
    #1;
    reset = 1'b0;

    measure_clear("clear_len", 16);

    for (int a = 0; a < DEPTH; a++)
      do_cycle(1, AW'(a), '0, '0, 1, AW'(DEPTH - 1 - a), '0, '0, 1'b1);

    do_cycle(2, 4'd5, 32'hAABB_CCDD, 4'hF, 0, '0, '0, '0, 1'b1);
    do_cycle(2, 4'd5, 32'h1122_3344, 4'h5, 0, '0, '0, '0, 1'b1);
    do_cycle(0, '0, '0, '0, 1, 4'd5, '0, '0, 1'b1);
    do_cycle(2, 4'd6, 32'hCAFE_F00D, 4'hF, 0, '0, '0, '0, 1'b1);
    do_cycle(1, 4'd6, '0, '0, 0, '0, '0, '0, 1'b1);
    do_cycle(2, 4'd7, 32'h0102_0304, 4'h3, 2, 4'd7, 32'hF0F0_F0F0, 4'hE, 1'b1);
    do_cycle(1, 4'd7, '0, '0, 0, '0, '0, '0, 1'b1);
    do_cycle(2, 4'd9, 32'hDEAD_BEEF, 4'hF, 1, 4'd9, '0, '0, 1'b1);
    do_cycle(1, 4'd4, '0, '0, 2, 4'd4, 32'h5566_7788, 4'h6, 1'b1);
    do_cycle(3, 4'd8, 32'h0BAD_C0DE, 4'hF, 1, 4'd8, '0, '0, 1'b1);
    do_cycle(1, 4'd8, '0, '0, 0, '0, '0, '0, 1'b1);
    idles(LAT + 1);

    do_cycle(0, '0, '0, '0, 1, 4'd5, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      clken = 1'b0;
      drive(1, 2, 4'd5, 32'h7777_7777, 4'hF);
      @(negedge clk);
      check("stall_valid_low", 64'(s2_if.readdatavalid), 64'(0));
      @(posedge clk);
      #1;
    end
    idle();
    clken = 1'b1;
    idles(LAT + 2);
    check("readdata_hold", 64'({s2_if.readdatavalid, s2_if.readdata}), 64'({1'b0, ref_mem[5]}));

    for (int i = 0; i < 400; i++) begin
      op1 = int'($urandom_range(0, 3));
      op2 = int'($urandom_range(0, 3));
      a1  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
      a2  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
      en  = ($urandom_range(0, 9) != 0);
      do_cycle(op1, a1, $urandom(), 4'($urandom_range(0, 15)),
               op2, a2, $urandom(), 4'($urandom_range(0, 15)), en);
    end
    idles(LAT + 2);

    do_cycle(2, 4'd10, 32'h1234_5678, 4'hF, 2, 4'd3, 32'h8765_4321, 4'hF, 1'b1);
    idles(1);
    apply_reset(1);
    idles(6);
    @(negedge clk);
    check("midclear_busy", 64'(clear_busy), 64'(1));
    @(posedge clk);
    en_edges++;
    #1;
    apply_reset(1);
    measure_clear("clear_restart_len", 16);
    for (int a = 0; a < DEPTH; a++)
      do_cycle(0, '0, '0, '0, 1, AW'(a), '0, '0, 1'b1);

    idles(LAT + 3);
    check("s1_queue_drained", 64'(q1.size()), 64'(0));
    check("s2_queue_drained", 64'(q2.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
